seed_candidates: RTL and testbench

//  Generates the initial candidate list for the ICBLBC code search. It walks

---
 rtl/seed_candidates.sv | 166 ++++++++++++++++
 tb/tb_seed_candidates.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seed_candidates.sv
// Walks every n-bit codeword in ascending order and writes the ones that pass the
// minimum-weight / single-code exclusion filters into the candidate RAM.
module seed_candidates #(
  parameter int MAX_N = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] n_bits,
  input  logic [3:0] min_weight,
  input  logic       exclude_en,
  input  logic [7:0] exclude_code,
  input  logic [7:0] base_addr,
  output logic [7:0] addr_cand,
  output logic [7:0] data_cand,
  output logic       wren_cand,
  output logic [7:0] cand_last,
  output logic       cand_empty,
  output logic       busy,
  output logic       complete,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_EVAL  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next_state;

  logic       r_start_1, r_start_2, r_start_3;
  logic       r_valid_1, r_valid_2;
  logic       r_armed;
  logic       r_edge;

  logic [7:0] r_mask;
  logic [8:0] r_limit;
  logic [3:0] r_min_weight;
  logic       r_excl_en;
  logic [7:0] r_excl_code;
  logic [7:0] r_base;
  logic [8:0] r_code;
  logic [8:0] r_wcount;
  logic       r_pass;

  logic [3:0] w_n_eff;
  logic [7:0] w_masked;
  logic [3:0] w_pop;
  logic       w_pass;
  logic [8:0] w_code_next;

  assign dbg_state = r_state;

  always_comb begin
    w_n_eff = n_bits;
    if (n_bits == 4'd0)
      w_n_eff = 4'd1;
    else if (n_bits > 4'(MAX_N))
      w_n_eff = 4'(MAX_N);
  end

  always_comb begin
    w_masked = r_code[7:0] & r_mask;
    w_pop    = '0;
    for (int i = 0; i < 8; i++)
      w_pop = w_pop + {3'b000, w_masked[i]};
    w_pass      = (w_pop >= r_min_weight) &&
                  !(r_excl_en && (r_code == {1'b0, r_excl_code}));
    w_code_next = r_code + 9'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= ST_RST;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RST:   w_next_state = ST_IDLE;
      ST_IDLE:  if (r_edge) w_next_state = ST_EVAL;
      ST_EVAL:  w_next_state = ST_WRITE;
      ST_WRITE: w_next_state = (w_code_next == r_limit) ? ST_DONE : ST_EVAL;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_RST;
    endcase
  end

  // The edge detector is only armed once a genuine post-reset sample of start
  // has been seen low, so a start held across reset cannot launch a run.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_start_1    <= 1'b0;
      r_start_2    <= 1'b0;
      r_start_3    <= 1'b0;
      r_valid_1    <= 1'b0;
      r_valid_2    <= 1'b0;
      r_armed      <= 1'b0;
      r_edge       <= 1'b0;
      r_mask       <= '0;
      r_limit      <= '0;
      r_min_weight <= '0;
      r_excl_en    <= 1'b0;
      r_excl_code  <= '0;
      r_base       <= '0;
      r_code       <= '0;
      r_wcount     <= '0;
      r_pass       <= 1'b0;
      addr_cand    <= '0;
      data_cand    <= '0;
      wren_cand    <= 1'b0;
      cand_last    <= '0;
      cand_empty   <= 1'b0;
      busy         <= 1'b0;
      complete     <= 1'b0;
    end else begin
      r_start_1 <= start;
      r_start_2 <= r_start_1;
      r_start_3 <= r_start_2;
      r_valid_1 <= 1'b1;
      r_valid_2 <= r_valid_1;
      if (r_valid_2 && !r_start_2)
        r_armed <= 1'b1;
      r_edge    <= r_start_2 & ~r_start_3 & r_armed;
      wren_cand <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_edge) begin
            r_mask       <= 8'((9'd1 << w_n_eff) - 9'd1);
            r_limit      <= 9'd1 << w_n_eff;
            r_min_weight <= min_weight;
            r_excl_en    <= exclude_en;
            r_excl_code  <= exclude_code;
            r_base       <= base_addr;
            r_code       <= '0;
            r_wcount     <= '0;
            complete     <= 1'b0;
            busy         <= 1'b1;
          end
        end
        ST_EVAL: r_pass <= w_pass;
        ST_WRITE: begin
          if (r_pass) begin
            wren_cand <= 1'b1;
            addr_cand <= r_base + r_wcount[7:0];
            data_cand <= r_code[7:0];
            r_wcount  <= r_wcount + 9'd1;
          end
          r_code <= w_code_next;
        end
        ST_DONE: begin
          cand_empty <= (r_wcount == 9'd0);
          cand_last  <= (r_wcount == 9'd0) ? 8'd0 : r_wcount[7:0] - 8'd1;
          complete   <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seed_candidates.sv
// Bench for seed_candidates: table of directed runs, random runs against a
// behavioural candidate-list model, and hand sequences for reset/retrigger.
module tb_seed_candidates;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] n_bits;
  logic [3:0] min_weight;
  logic       exclude_en;
  logic [7:0] exclude_code;
  logic [7:0] base_addr;
  logic [7:0] addr_cand;
  logic [7:0] data_cand;
  logic       wren_cand;
  logic [7:0] cand_last;
  logic       cand_empty;
  logic       busy;
  logic       complete;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected writes, {addr, data}, in issue order.
  logic [15:0] exp_q[$];
  logic        prev_wren = 1'b0;

  typedef struct {
    int n;
    int mw;
    int ee;
    int ec;
    int base;
    int exp_last;
    int exp_empty;
  } vec_t;

  vec_t vecs[7];

  seed_candidates #(.MAX_N(8)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .n_bits(n_bits),
    .min_weight(min_weight), .exclude_en(exclude_en), .exclude_code(exclude_code),
    .base_addr(base_addr), .addr_cand(addr_cand), .data_cand(data_cand),
    .wren_cand(wren_cand), .cand_last(cand_last), .cand_empty(cand_empty),
    .busy(busy), .complete(complete), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // scoreboard: every write must match the head of the expected queue
  always @(negedge clock) begin
    if (reset_n === 1'b1 && wren_cand === 1'b1) begin
      check("write_spacing", int'(prev_wren), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {16'd0, addr_cand, data_cand}, -1);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("write_addr_data", {16'd0, addr_cand, data_cand}, {16'd0, e});
      end
    end
    prev_wren = wren_cand;
  end

  function automatic int eff_n(input int n);
    if (n == 0) return 1;
    if (n > 8) return 8;
    return n;
  endfunction

  // reference model: filter every code 0..2**n-1 in order
  task automatic build_expected(input int n, input int mw, input int ee, input int ec,
                                input int base, output int m_last, output int m_empty);
    int cnt;
    logic [7:0] c8, a8;
    exp_q.delete();
    cnt = 0;
    for (int c = 0; c < (1 << eff_n(n)); c++) begin
      c8 = c[7:0];
      if ($countones(c8) >= mw && !(ee != 0 && c == ec)) begin
        a8 = 8'(base + cnt);
        exp_q.push_back({a8, c8});
        cnt++;
      end
    end
    m_last  = (cnt == 0) ? 0 : cnt - 1;
    m_empty = (cnt == 0) ? 1 : 0;
  endtask

  task automatic drive_cfg(input int n, input int mw, input int ee, input int ec, input int base);
    n_bits       = 4'(n);
    min_weight   = 4'(mw);
    exclude_en   = 1'(ee);
    exclude_code = 8'(ec);
    base_addr    = 8'(base);
  endtask

  // exp_last < 0 means take last/empty from the model
  task automatic run_case(input string tag, input int n, input int mw, input int ee,
                          input int ec, input int base, input int exp_last,
                          input int exp_empty, input bit toggle);
    int m_last, m_empty, k, exp_cycles;
    bit got, prev;
    start = 1'b0;
    repeat (4) @(negedge clock);
    drive_cfg(n, mw, ee, ec, base);
    build_expected(n, mw, ee, ec, base, m_last, m_empty);
    if (exp_last < 0) begin
      exp_last  = m_last;
      exp_empty = m_empty;
    end
    exp_cycles = 4 + 2 * (1 << eff_n(n)) + 1;
    start = 1'b1;
    prev = complete;
    got = 1'b0;
    k = 0;
    while (k < 3000 && !got) begin
      @(posedge clock);
      #1;
      k++;
      if (toggle && k == 6) start = 1'b0;
      if (toggle && k == 8) start = 1'b1;
      if (complete && !prev) got = 1'b1;
      prev = complete;
    end
    if (!got) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check({tag, "_latency"}, k, exp_cycles);
      check({tag, "_writes_left"}, exp_q.size(), 0);
      check({tag, "_cand_last"}, int'(cand_last), exp_last);
      check({tag, "_cand_empty"}, int'(cand_empty), exp_empty);
      check({tag, "_busy"}, int'(busy), 0);
    end
  endtask

  initial begin
    int cnt, k;
    bit any_busy;

    vecs[0] = '{n:3,  mw:0, ee:0, ec:0,   base:'h10, exp_last:7,   exp_empty:0};
    vecs[1] = '{n:4,  mw:2, ee:0, ec:0,   base:'h00, exp_last:10,  exp_empty:0};
    vecs[2] = '{n:3,  mw:0, ee:1, ec:0,   base:'h40, exp_last:6,   exp_empty:0};
    vecs[3] = '{n:8,  mw:0, ee:0, ec:0,   base:'hF0, exp_last:255, exp_empty:0};
    vecs[4] = '{n:2,  mw:3, ee:0, ec:0,   base:'h00, exp_last:0,   exp_empty:1};
    vecs[5] = '{n:0,  mw:1, ee:0, ec:0,   base:'h05, exp_last:0,   exp_empty:0};
    vecs[6] = '{n:12, mw:8, ee:1, ec:200, base:'h80, exp_last:0,   exp_empty:0};

    reset_n = 1'b0;
    start   = 1'b0;
    drive_cfg(0, 0, 0, 0, 0);
    repeat (3) @(posedge clock);
    #1;
    check("rst_state", int'(dbg_state), 0);
    check("rst_outputs", {16'd0, wren_cand, busy, complete, cand_empty, addr_cand | data_cand | cand_last}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("rst_to_idle", int'(dbg_state), 1);
    repeat (4) @(negedge clock);

    foreach (vecs[i])
      run_case($sformatf("vec%0d", i), vecs[i].n, vecs[i].mw, vecs[i].ee, vecs[i].ec,
               vecs[i].base, vecs[i].exp_last, vecs[i].exp_empty, 1'b0);

    for (int r = 0; r < 10; r++) begin
      int rn, rmw, ree, rec;
      rn  = $urandom_range(0, 10);
      rmw = $urandom_range(0, 9);
      ree = $urandom_range(0, 1);
      rec = $urandom_range(0, 15);
      run_case($sformatf("rnd%0d", r), rn, rmw, ree, rec, $urandom_range(0, 255), -1, 0, 1'b0);
    end

    // a second start edge while busy must not restart or disturb the run
    run_case("retrigger", 3, 1, 0, 0, 'h30, 6, 0, 1'b1);

    // reset during the 5th write with start held high
    begin
      int m_last, m_empty;
      start = 1'b0;
      repeat (4) @(negedge clock);
      drive_cfg(4, 0, 0, 0, 'h20);
      build_expected(4, 0, 0, 0, 'h20, m_last, m_empty);
      start = 1'b1;
      cnt = 0;
      k = 0;
      while (k < 200 && cnt < 5) begin
        @(posedge clock);
        #1;
        k++;
        if (wren_cand) cnt++;
      end
      check("midrun_reached_5th_write", cnt, 5);
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      check("midrun_wren_off", int'(wren_cand), 0);
      check("midrun_busy_off", int'(busy), 0);
      @(negedge clock);
      exp_q.delete();
      @(negedge clock);
      reset_n = 1'b1;
      any_busy = 1'b0;
      repeat (40) begin
        @(posedge clock);
        #1;
        if (busy || wren_cand) any_busy = 1'b1;
      end
      check("held_start_no_run", int'(any_busy), 0);
    end

    // start falls and rises again: normal run resumes
    run_case("after_reset", 3, 0, 0, 0, 'h10, 7, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
